// File: rtl/scmp_bus_seq.sv
// rtl/scmp_bus_seq.sv - SC/MP-style multiplexed external bus sequencer
// One request at a time: optional BREQ/ENIN arbitration, address strobe, data strobe, recovery.
module scmp_bus_seq #(
    parameter int AW          = 16,
    parameter int ALO         = 12,
    parameter int ADS_CYCLES  = 1,
    parameter int DATA_CYCLES = 2,
    parameter int RECOVERY    = 1,
    parameter int ARB_EN      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_wdata,
    input  logic [3:0]    req_flags,
    output logic          resp_valid,
    output logic [7:0]    resp_rdata,
    output logic          busy,
    output logic [ALO-1:0] addr,
    input  logic [7:0]    D_i,
    output logic [7:0]    D_o,
    output logic          D_oe,
    output logic          ADS_n,
    output logic          RD_n,
    output logic          WR_n,
    input  logic          nhold,
    output logic          breq,
    input  logic          enin,
    output logic          enout
);

    localparam int CW = 8;
    localparam logic [CW-1:0] ADS_LD  = CW'(ADS_CYCLES - 1);
    localparam logic [CW-1:0] DATA_LD = CW'(DATA_CYCLES - 1);
    localparam logic [CW-1:0] REC_LD  = CW'(RECOVERY - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        REC  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic [AW-1:0] a_r;
    logic [7:0]    wdata_r;
    logic          we_r;
    logic [3:0]    flags_r;

    logic          accept;
    logic [AW-1:0] a_n;
    logic [7:0]    wdata_n;
    logic          we_n;
    logic [3:0]    flags_n;
    logic [3:0]    ahi_n;

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign enout     = enin & ~breq;

    // Registered outputs are computed from the upcoming state, so the request
    // fields are forwarded from the inputs on the accept edge.
    assign a_n     = accept ? req_addr  : a_r;
    assign wdata_n = accept ? req_wdata : wdata_r;
    assign we_n    = accept ? req_we    : we_r;
    assign flags_n = accept ? req_flags : flags_r;
    assign ahi_n   = 4'(a_n >> ALO);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (ARB_EN != 0) begin
                        state_next = ARB;
                    end else begin
                        state_next = ADDR;
                        cnt_next   = ADS_LD;
                    end
                end
            end
            ARB: begin
                if (enin) begin
                    state_next = ADDR;
                    cnt_next   = ADS_LD;
                end
            end
            ADDR: begin
                if (cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = DATA_LD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            DATA: begin
                // nhold only matters once the minimum strobe width has elapsed
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (nhold) begin
                    if (RECOVERY == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = REC;
                        cnt_next   = REC_LD;
                    end
                end
            end
            REC: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_r     <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
            flags_r <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                a_r     <= req_addr;
                wdata_r <= req_wdata;
                we_r    <= req_we;
                flags_r <= req_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ADS_n      <= 1'b1;
            RD_n       <= 1'b1;
            WR_n       <= 1'b1;
            breq       <= 1'b0;
            D_oe       <= 1'b0;
            D_o        <= '0;
            addr       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            ADS_n <= !(state_next == ADDR);
            RD_n  <= !((state_next == DATA) && !we_n);
            WR_n  <= !((state_next == DATA) && we_n);
            D_oe  <= (state_next == ADDR) || ((state_next == DATA) && we_n);
            breq  <= (ARB_EN != 0) &&
                     ((state_next == ARB) || (state_next == ADDR) || (state_next == DATA));
            if (state_next == ADDR) begin
                D_o  <= {flags_n, ahi_n};
                addr <= a_n[ALO-1:0];
            end else if ((state_next == DATA) && we_n) begin
                D_o <= wdata_n;
            end else begin
                D_o <= '0;
            end
            resp_valid <= (state == DATA) && (state_next != DATA);
            if ((state == DATA) && (state_next != DATA) && !we_r) begin
                resp_rdata <= D_i;
            end
        end
    end

endmodule
